vram_pipe_model: RTL and testbench

Parametrised, pipelined VRAM responder for VDP-level benches and FPGA bring-up builds. It succeeds the single-outstanding, fixed-delay VRAM model used with the `vdp` core. It accepts one byte-write or word-read per cycle and returns read data after a configurable latency with full pipelining. It optionally injects periodic refresh stalls through a ready handshake. It sits directly on the `vdp` VRAM port: `vram_address`/`vram_write`/`vram_valid`/`vram_wdata` in, `vram_rdata`/`vram_rdata_en` out.

---
 rtl/vram_model_pkg.sv | 31 +++
 rtl/vram_read_pipe.sv | 43 ++++
 rtl/vram_pipe_model.sv | 113 +++++++++++
 tb/tb_vram_pipe_model.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vram_model_pkg.sv
// Shared types and elaboration helpers for the pipelined VRAM responder.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package vram_model_pkg;

  // Widest byte address the request record can carry.
  localparam int VRAM_ADDR_MAX_W = 32;

  typedef struct packed {
    logic [VRAM_ADDR_MAX_W-1:0] addr;
    logic                       write;
    logic [7:0]                 wdata;
  } vram_req_t;

  // Number of address bits that select a byte within one read word.
  function automatic int lane_bits(input int rdata_w);
    return $clog2(rdata_w / 8);
  endfunction

  // Read word must be a power-of-two number of bytes.
  function automatic bit rdata_w_legal(input int rdata_w);
    int bytes;
    bytes = rdata_w / 8;
    return (rdata_w >= 8) && ((rdata_w % 8) == 0) && ((bytes & (bytes - 1)) == 0);
  endfunction

  function automatic bit latency_legal(input int latency);
    return (latency >= 1) && (latency <= 8);
  endfunction

endpackage

// File: rtl/vram_read_pipe.sv
// Fixed-depth valid/data shift register carrying read snapshots to the output.
// Latency: push at edge N appears on pop in the cycle after edge N+LATENCY-1.
// Backpressure: none; every pushed entry emerges in order, never stalls.
module vram_read_pipe #(
  parameter int LATENCY = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop,
  output logic [DATA_W-1:0] pop_data
);

  logic [LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  // Shift valid every cycle; data only moves with a valid so the last stage holds between pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= push;
      if (push) begin
        data_q[0] <= push_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign pop      = valid_q[LATENCY-1];
  assign pop_data = data_q[LATENCY-1];

endmodule

// File: rtl/vram_pipe_model.sv
// Pipelined VRAM responder: byte writes, word reads returned in order. Refresh stalls under VRAM_REFRESH_STALL_EN.
// Latency: read accepted at edge N pulses vram_rdata_en in the cycle after edge N+LATENCY-1.
// Backpressure: vram_ready is 1 always, or 0 during the refresh window when the macro is defined.
module vram_pipe_model
  import vram_model_pkg::*;
#(
  parameter int ADDR_W         = 17,
  parameter int RDATA_W        = 32,
  parameter int LATENCY        = 3,
  parameter int REFRESH_PERIOD = 1368,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  vram_address,
  input  logic               vram_write,
  input  logic               vram_valid,
  input  logic [7:0]         vram_wdata,
  output logic               vram_ready,
  output logic [RDATA_W-1:0] vram_rdata,
  output logic               vram_rdata_en
);

  localparam int LANE_W     = lane_bits(RDATA_W);
  localparam int WORD_W     = ADDR_W - LANE_W;
  localparam int DEPTH      = 2 ** WORD_W;
  localparam int LANE_IDX_W = (LANE_W > 0) ? LANE_W : 1;

  if (!rdata_w_legal(RDATA_W)) begin : g_bad_rdata_w
    $error("vram_pipe_model: RDATA_W must be 8*2^n");
  end
  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("vram_pipe_model: LATENCY must be within 1..8");
  end
  if (REFRESH_CYCLES >= REFRESH_PERIOD) begin : g_bad_refresh
    $error("vram_pipe_model: REFRESH_CYCLES must be below REFRESH_PERIOD");
  end
  if ((ADDR_W > VRAM_ADDR_MAX_W) || (ADDR_W <= LANE_W)) begin : g_bad_addr_w
    $error("vram_pipe_model: ADDR_W out of range");
  end

  vram_req_t               req;
  logic                    accept;
  logic [WORD_W-1:0]       word_idx;
  logic [LANE_IDX_W-1:0]   lane;
  logic [RDATA_W-1:0]      mem_q [DEPTH];

  assign req.addr  = VRAM_ADDR_MAX_W'(vram_address);
  assign req.write = vram_write;
  assign req.wdata = vram_wdata;
  assign accept    = vram_valid && vram_ready;
  assign word_idx  = req.addr[ADDR_W-1:LANE_W];

  if (LANE_W > 0) begin : g_lane
    assign lane = req.addr[LANE_W-1:0];
  end else begin : g_no_lane
    assign lane = '0;
  end

  if (ADDR_W < VRAM_ADDR_MAX_W) begin : g_addr_pad
    logic unused_addr_hi;
    assign unused_addr_hi = |req.addr[VRAM_ADDR_MAX_W-1:ADDR_W];
  end

  // Byte-lane write into the addressed word; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (accept && req.write) begin
      mem_q[word_idx][{lane, 3'b000} +: 8] <= req.wdata;
    end
  end

  // The word is snapshotted here, so later writes cannot disturb an in-flight read.
  vram_read_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (RDATA_W)
  ) u_read_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept && !req.write),
    .push_data (mem_q[word_idx]),
    .pop       (vram_rdata_en),
    .pop_data  (vram_rdata)
  );

`ifdef VRAM_REFRESH_STALL_EN
  localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  logic [CNT_W-1:0] refresh_cnt_q;
  logic [CNT_W-1:0] refresh_cnt_d;

  // Free-running refresh phase counter wrapping at REFRESH_PERIOD-1.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    if (refresh_cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
      refresh_cnt_d = '0;
    end
  end

  // Counter restarts at zero on reset so the first window stalls immediately.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refresh_cnt_q <= '0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
    end
  end

  assign vram_ready = (refresh_cnt_q >= CNT_W'(REFRESH_CYCLES));
`else
  assign vram_ready = 1'b1;
`endif

endmodule

// File: tb/tb_vram_pipe_model.sv
// Directed bench for vram_pipe_model: three latency builds driven in lockstep.
// Latency: pulse timestamps are checked against the accept cycle of each read.
// Backpressure: requests wait on vram_ready with a bounded retry count.
module tb_vram_pipe_model;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [16:0] addr;
  logic        wr;
  logic        vld;
  logic [7:0]  wdata;

  logic        rdy0, rdy1, rdy8;
  logic        en0, en1, en8;
  logic [31:0] dat0, dat1, dat8;

  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  int          checks = 0;
  int          errors = 0;
  int          lat [3] = '{3, 1, 8};

  typedef struct {
    int unsigned cyc;
    logic [31:0] dat;
  } pulse_t;

  pulse_t pq [3][$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vram_pipe_model u_dut (
    .clk(clk), .reset_n(reset_n), .vram_address(addr), .vram_write(wr),
    .vram_valid(vld), .vram_wdata(wdata), .vram_ready(rdy0),
    .vram_rdata(dat0), .vram_rdata_en(en0)
  );

  vram_pipe_model #(.ADDR_W(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .vram_address(addr[7:0]), .vram_write(wr),
    .vram_valid(vld), .vram_wdata(wdata), .vram_ready(rdy1),
    .vram_rdata(dat1), .vram_rdata_en(en1)
  );

  vram_pipe_model #(.ADDR_W(8), .LATENCY(8)) u_lat8 (
    .clk(clk), .reset_n(reset_n), .vram_address(addr[7:0]), .vram_write(wr),
    .vram_valid(vld), .vram_wdata(wdata), .vram_ready(rdy8),
    .vram_rdata(dat8), .vram_rdata_en(en8)
  );

`ifdef VRAM_REFRESH_STALL_EN
  localparam logic RDY_AT_RESET = 1'b0;
  logic        rf_reset_n = 1'b0;
  logic        rf_vld = 1'b0;
  logic        rf_rdy, rf_en;
  logic [31:0] rf_dat;

  vram_pipe_model #(.ADDR_W(8), .REFRESH_PERIOD(16), .REFRESH_CYCLES(4)) u_rf (
    .clk(clk), .reset_n(rf_reset_n), .vram_address(8'h00), .vram_write(1'b0),
    .vram_valid(rf_vld), .vram_wdata(8'h00), .vram_ready(rf_rdy),
    .vram_rdata(rf_dat), .vram_rdata_en(rf_en)
  );
`else
  localparam logic RDY_AT_RESET = 1'b1;
`endif

  // Record every pulse with the edge count at which it became visible.
  always @(negedge clk) begin
    pulse_t p;
    p.cyc = cyc;
    if (en0 === 1'b1) begin p.dat = dat0; pq[0].push_back(p); end
    if (en1 === 1'b1) begin p.dat = dat1; pq[1].push_back(p); end
    if (en8 === 1'b1) begin p.dat = dat8; pq[2].push_back(p); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [16:0] a, input logic w, input logic [7:0] d);
    logic acc;
    acc   = 1'b0;
    addr  = a;
    wr    = w;
    wdata = d;
    vld   = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (rdy0 === 1'b1) acc = 1'b1;
      tick();
    end
    last_acc = cyc;
    chk("req_accept", acc, 1);
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clearq();
    for (int i = 0; i < 3; i++) pq[i].delete();
  endtask

  task automatic expect_pulses(input string tag, input int inst, input int n,
                               input int unsigned first, input int stride,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] dv [4];
    dv = '{d0, d1, d2, d3};
    chk($sformatf("%s_i%0d_count", tag, inst), pq[inst].size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < pq[inst].size()) begin
        chk($sformatf("%s_i%0d_cyc%0d", tag, inst, k), pq[inst][k].cyc, first + k * stride);
        chk($sformatf("%s_i%0d_dat%0d", tag, inst, k), pq[inst][k].dat, dv[k]);
      end
    end
  endtask

  initial begin
    int unsigned n;
    reset_n = 1'b0;
    vld     = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdata   = '0;
    tick();
    tick();

    // Reset state
    chk("rst_en0", en0, 0);
    chk("rst_dat0", dat0, 0);
    chk("rst_en8", en8, 0);
    chk("rst_rdy0", rdy0, RDY_AT_RESET);
    reset_n = 1'b1;
    clearq();

    // 1: four byte writes assemble one word
    req(17'h00000, 1'b1, 8'h11);
    req(17'h00001, 1'b1, 8'h22);
    req(17'h00002, 1'b1, 8'h33);
    req(17'h00003, 1'b1, 8'h44);
    clearq();
    req(17'h00000, 1'b0, 8'h00);
    n = last_acc;
    idle(12);
    for (int i = 0; i < 3; i++)
      expect_pulses("s1", i, 1, n + lat[i] - 1, 1, 32'h44332211, '0, '0, '0);
    chk("s1_hold", dat0, 32'h44332211);

    // 2: back-to-back reads of words 0..3
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        req(17'(w * 4 + b), 1'b1, (b == 0) ? 8'(8'hA0 + w) : 8'h00);
    clearq();
    n = 0;
    for (int w = 0; w < 4; w++) begin
      req(17'(w * 4), 1'b0, 8'h00);
      if (w == 0) n = last_acc;
    end
    idle(14);
    for (int i = 0; i < 3; i++)
      expect_pulses("s2", i, 4, n + lat[i] - 1, 1,
                    32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3);

    // 3: snapshot read followed by a write to the same word
    req(17'd20, 1'b1, 8'h55);
    req(17'd21, 1'b1, 8'h66);
    req(17'd22, 1'b1, 8'h77);
    req(17'd23, 1'b1, 8'h88);
    clearq();
    req(17'd20, 1'b0, 8'h00);
    n = last_acc;
    req(17'd20, 1'b1, 8'hFF);
    req(17'd20, 1'b0, 8'h00);
    idle(12);
    for (int i = 0; i < 3; i++)
      expect_pulses("s3", i, 2, n + lat[i] - 1, 2, 32'h88776655, 32'h887766FF, '0, '0);

    // 4: reset with reads in flight
    req(17'd0, 1'b0, 8'h00);
    req(17'd4, 1'b0, 8'h00);
    vld     = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clearq();
    chk("s4_en0", en0, 0);
    chk("s4_dat0", dat0, 0);
    chk("s4_dat1", dat1, 0);
    chk("s4_dat8", dat8, 0);
    idle(12);
    for (int i = 0; i < 3; i++)
      chk($sformatf("s4_nopulse_i%0d", i), pq[i].size(), 0);
    req(17'd20, 1'b0, 8'h00);
    n = last_acc;
    idle(12);
    for (int i = 0; i < 3; i++)
      expect_pulses("s4_mem", i, 1, n + lat[i] - 1, 1, 32'h887766FF, '0, '0, '0);

`ifdef VRAM_REFRESH_STALL_EN
    // 6: refresh window with a read held across the stall
    rf_reset_n = 1'b0;
    tick();
    rf_reset_n = 1'b1;
    for (int k = 0; k < 26; k++) begin
      chk($sformatf("s6_rdy_c%0d", k), rf_rdy, ((k % 16) >= 4) ? 1 : 0);
      chk($sformatf("s6_en_c%0d", k), rf_en, (k == 23) ? 1 : 0);
      rf_vld = (k >= 16) && (k <= 20);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
